// File: rtl/ulpb_layer_ctrl.sv
// Link-layer controller between a host and a ULPB-style node: buffered TX
// message sequencing with word handshakes, and single-message RX capture.
module ulpb_layer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [7:0]            TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  input  logic [7:0]            RX_ADDR,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_REQ,
  input  logic                  RX_PEND,
  output logic                  RX_ACK,
  input  logic                  HOST_TX_WR,
  input  logic [DATA_WIDTH-1:0] HOST_TX_WDATA,
  input  logic [7:0]            HOST_TX_DEST,
  input  logic                  HOST_TX_START,
  output logic                  HOST_TX_BUSY,
  output logic                  HOST_TX_DONE,
  output logic                  HOST_TX_OK,
  output logic                  HOST_RX_VALID,
  output logic [7:0]            HOST_RX_ADDR,
  output logic [DATA_WIDTH-1:0] HOST_RX_RDATA,
  input  logic                  HOST_RX_RD,
  output logic                  HOST_RX_ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_REQ  = 3'd1;
  localparam logic [2:0] T_GAP  = 3'd2;
  localparam logic [2:0] T_WAIT = 3'd3;
  localparam logic [2:0] T_RESP = 3'd4;

  logic [2:0]            tx_state;
  logic [DATA_WIDTH-1:0] tx_buf [DEPTH];
  logic [PW-1:0]         tx_cnt;
  logic [PW-1:0]         tx_rd;
  logic [PW-1:0]         tx_rd_nxt;
  logic                  tx_wr_en;

  logic [DATA_WIDTH-1:0] rx_buf [DEPTH];
  logic [PW-1:0]         rx_wr;
  logic [PW-1:0]         rx_rd;
  logic                  rx_take;
  logic                  rx_pop;

  assign tx_rd_nxt = tx_rd + ONE;
  assign tx_wr_en  = HOST_TX_WR && (tx_state == T_IDLE) && (tx_cnt != FULL);

  // NOTE: message buffers carry no reset; the counts gate every read, so
  // stale contents are never visible and the RAMs stay reset-free.
  always_ff @(posedge CLK) begin
    if (tx_wr_en)
      tx_buf[tx_cnt[AW-1:0]] <= HOST_TX_WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_state   <= T_IDLE;
      tx_cnt     <= '0;
      tx_rd      <= '0;
      TX_ADDR    <= '0;
      HOST_TX_OK <= 1'b0;
    end else begin
      if (tx_wr_en)
        tx_cnt <= tx_cnt + ONE;
      case (tx_state)
        T_IDLE: begin
          if (HOST_TX_START && (tx_cnt != '0)) begin
            TX_ADDR  <= HOST_TX_DEST;
            tx_rd    <= '0;
            tx_state <= T_REQ;
          end
        end
        T_REQ: begin
          if (TX_FAIL) begin
            HOST_TX_OK <= 1'b0;
            tx_state   <= T_RESP;
          end else if (TX_ACK) begin
            tx_rd    <= tx_rd_nxt;
            tx_state <= (tx_rd_nxt < tx_cnt) ? T_GAP : T_WAIT;
          end
        end
        T_GAP: begin
          // Wait for the node to drop ACK so the next word is a fresh request.
          if (TX_FAIL) begin
            HOST_TX_OK <= 1'b0;
            tx_state   <= T_RESP;
          end else if (!TX_ACK) begin
            tx_state <= T_REQ;
          end
        end
        T_WAIT: begin
          if (TX_SUCC || TX_FAIL) begin
            HOST_TX_OK <= TX_SUCC && !TX_FAIL;
            tx_state   <= T_RESP;
          end
        end
        T_RESP: begin
          tx_cnt   <= '0;
          tx_rd    <= '0;
          tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // NOTE: handshake outputs are decoded straight from state with continuous
  // assigns, so there is no incompletely assigned combinational process.
  assign TX_REQ       = (tx_state == T_REQ);
  assign TX_PEND      = TX_REQ && (tx_rd_nxt < tx_cnt);
  assign TX_DATA      = TX_REQ ? tx_buf[tx_rd[AW-1:0]] : '0;
  assign TX_RESP_ACK  = (tx_state == T_RESP);
  assign HOST_TX_DONE = (tx_state == T_RESP);
  assign HOST_TX_BUSY = (tx_state != T_IDLE);

  assign rx_take = RX_REQ && !RX_ACK && !HOST_RX_VALID;
  assign rx_pop  = HOST_RX_RD && HOST_RX_VALID;

  always_ff @(posedge CLK) begin
    if (rx_take && (rx_wr != FULL))
      rx_buf[rx_wr[AW-1:0]] <= RX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      RX_ACK        <= 1'b0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      HOST_RX_VALID <= 1'b0;
      HOST_RX_ADDR  <= '0;
      HOST_RX_ERR   <= 1'b0;
    end else begin
      if (rx_take) begin
        RX_ACK <= 1'b1;
        if (rx_wr == '0)
          HOST_RX_ADDR <= RX_ADDR;
        // Overflow words are still acknowledged so the node can finish.
        if (rx_wr != FULL)
          rx_wr <= rx_wr + ONE;
        else
          HOST_RX_ERR <= 1'b1;
        if (!RX_PEND)
          HOST_RX_VALID <= 1'b1;
      end else if (RX_ACK && !RX_REQ) begin
        RX_ACK <= 1'b0;
      end
      if (rx_pop) begin
        if ((rx_rd + ONE) == rx_wr) begin
          HOST_RX_VALID <= 1'b0;
          HOST_RX_ERR   <= 1'b0;
          rx_rd         <= '0;
          rx_wr         <= '0;
        end else begin
          rx_rd <= rx_rd + ONE;
        end
      end
    end
  end

  assign HOST_RX_RDATA = HOST_RX_VALID ? rx_buf[rx_rd[AW-1:0]] : '0;

endmodule

// File: tb/tb_ulpb_layer_ctrl.sv
// Directed bench for ulpb_layer_ctrl: a per-cycle vector table followed by
// hand-written multi-cycle TX/RX sequences (DATA_WIDTH=32, DEPTH=4).
module tb_ulpb_layer_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_PEND, TX_REQ, TX_RESP_ACK;
  logic        TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
  logic [7:0]  RX_ADDR = '0;
  logic [31:0] RX_DATA = '0;
  logic        RX_REQ = 1'b0, RX_PEND = 1'b0;
  logic        RX_ACK;
  logic        HOST_TX_WR = 1'b0, HOST_TX_START = 1'b0;
  logic [31:0] HOST_TX_WDATA = '0;
  logic [7:0]  HOST_TX_DEST = '0;
  logic        HOST_TX_BUSY, HOST_TX_DONE, HOST_TX_OK;
  logic        HOST_RX_VALID, HOST_RX_ERR;
  logic [7:0]  HOST_RX_ADDR;
  logic [31:0] HOST_RX_RDATA;
  logic        HOST_RX_RD = 1'b0;

  int total = 0;
  int bad   = 0;

  ulpb_layer_ctrl #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ), .RX_PEND(RX_PEND), .RX_ACK(RX_ACK),
    .HOST_TX_WR(HOST_TX_WR), .HOST_TX_WDATA(HOST_TX_WDATA), .HOST_TX_DEST(HOST_TX_DEST),
    .HOST_TX_START(HOST_TX_START), .HOST_TX_BUSY(HOST_TX_BUSY), .HOST_TX_DONE(HOST_TX_DONE),
    .HOST_TX_OK(HOST_TX_OK), .HOST_RX_VALID(HOST_RX_VALID), .HOST_RX_ADDR(HOST_RX_ADDR),
    .HOST_RX_RDATA(HOST_RX_RDATA), .HOST_RX_RD(HOST_RX_RD), .HOST_RX_ERR(HOST_RX_ERR)
  );

  always #5 CLK = ~CLK;

  // ctl  = {rst, wr, start, ack, succ, fail, rx_req, rx_pend, rx_rd}
  // flag = {tx_req, tx_pend, resp_ack, busy, done, ok, rx_ack, rx_valid, rx_err}
  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [31:0] wdata;
    logic [7:0]  dest;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [8:0]  e_flag;
    logic [7:0]  e_txaddr;
    logic [31:0] e_txdata;
    logic [7:0]  e_rxaddr;
    logic [31:0] e_rxdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic [8:0] c, logic [31:0] wd, logic [7:0] dst,
                              logic [7:0] ra, logic [31:0] rdt, logic [8:0] ef,
                              logic [7:0] eta, logic [31:0] etd, logic [7:0] era,
                              logic [31:0] erd);
    vec_t v;
    v.name = nm; v.ctl = c; v.wdata = wd; v.dest = dst; v.raddr = ra; v.rdata = rdt;
    v.e_flag = ef; v.e_txaddr = eta; v.e_txdata = etd; v.e_rxaddr = era; v.e_rxdata = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] flags();
    return {TX_REQ, TX_PEND, TX_RESP_ACK, HOST_TX_BUSY, HOST_TX_DONE, HOST_TX_OK,
            RX_ACK, HOST_RX_VALID, HOST_RX_ERR};
  endfunction

  task automatic wait_req(input string nm);
    int n = 0;
    while (TX_REQ !== 1'b1 && n < 20) begin tick(); n++; end
    check(nm, 64'(TX_REQ), 64'(1));
  endtask

  task automatic write_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      HOST_TX_WR = 1'b1; HOST_TX_WDATA = base + 32'(i); tick();
    end
    HOST_TX_WR = 1'b0;
  endtask

  task automatic start_msg(input logic [7:0] dest);
    HOST_TX_DEST = dest; HOST_TX_START = 1'b1; tick();
    HOST_TX_START = 1'b0; HOST_TX_DEST = 8'hFF;
  endtask

  // Writes n words, starts, and walks nexp word handshakes; ends in T_WAIT.
  task automatic run_tx(input string nm, input int n, input logic [31:0] base,
                        input logic [7:0] dest, input int nexp);
    write_words(n, base);
    start_msg(dest);
    check({nm, "_busy"}, 64'(HOST_TX_BUSY), 64'(1));
    for (int i = 0; i < nexp; i++) begin
      wait_req($sformatf("%s_req%0d", nm, i));
      check($sformatf("%s_pend%0d", nm, i), 64'(TX_PEND), 64'(i < nexp - 1));
      check($sformatf("%s_data%0d", nm, i), 64'(TX_DATA), 64'(base + 32'(i)));
      check($sformatf("%s_addr%0d", nm, i), 64'(TX_ADDR), 64'(dest));
      TX_ACK = 1'b1;
      for (int k = 0; k < 2; k++) begin
        tick();
        check($sformatf("%s_noreq%0d_%0d", nm, i, k), 64'(TX_REQ), 64'(0));
      end
      TX_ACK = 1'b0;
      tick();
    end
    tick();
    check({nm, "_wait_noreq"}, 64'(TX_REQ), 64'(0));
    check({nm, "_wait_busy"}, 64'(HOST_TX_BUSY), 64'(1));
  endtask

  task automatic rx_word(input string nm, input logic [7:0] a, input logic [31:0] d,
                         input logic p);
    int n = 0;
    RX_ADDR = a; RX_DATA = d; RX_PEND = p; RX_REQ = 1'b1;
    while (RX_ACK !== 1'b1 && n < 20) begin tick(); n++; end
    check({nm, "_ack"}, 64'(RX_ACK), 64'(1));
    RX_REQ = 1'b0;
    n = 0;
    while (RX_ACK !== 1'b0 && n < 20) begin tick(); n++; end
    check({nm, "_ackdrop"}, 64'(RX_ACK), 64'(0));
  endtask

  initial begin
    vq.push_back(mk("reset",    9'b100000000, 0, 0, 0, 0, 9'b000000000, 8'h00, 0, 8'h00, 0));
    vq.push_back(mk("wr1",      9'b010000000, 32'hA5A5A5A5, 0, 0, 0, 9'b000000000, 8'h00, 0, 8'h00, 0));
    vq.push_back(mk("start",    9'b001000000, 0, 8'h12, 0, 0, 9'b100100000, 8'h12, 32'hA5A5A5A5, 8'h00, 0));
    vq.push_back(mk("req_hold", 9'b000000000, 0, 0, 0, 0, 9'b100100000, 8'h12, 32'hA5A5A5A5, 8'h00, 0));
    vq.push_back(mk("ack",      9'b000100000, 0, 0, 0, 0, 9'b000100000, 8'h12, 0, 8'h00, 0));
    vq.push_back(mk("ack_low",  9'b000000000, 0, 0, 0, 0, 9'b000100000, 8'h12, 0, 8'h00, 0));
    vq.push_back(mk("succ",     9'b000010000, 0, 0, 0, 0, 9'b001111000, 8'h12, 0, 8'h00, 0));
    vq.push_back(mk("succ_hold",9'b000010000, 0, 0, 0, 0, 9'b000001000, 8'h12, 0, 8'h00, 0));
    vq.push_back(mk("succ_low", 9'b000000000, 0, 0, 0, 0, 9'b000001000, 8'h12, 0, 8'h00, 0));
    vq.push_back(mk("rx_w0",    9'b000000110, 0, 0, 8'h34, 32'h11111111, 9'b000001100, 8'h12, 0, 8'h34, 0));
    vq.push_back(mk("rx_w0_hold",9'b000000110, 0, 0, 8'h34, 32'h11111111, 9'b000001100, 8'h12, 0, 8'h34, 0));
    vq.push_back(mk("rx_w0_drop",9'b000000000, 0, 0, 0, 0, 9'b000001000, 8'h12, 0, 8'h34, 0));
    vq.push_back(mk("rx_w1",    9'b000000100, 0, 0, 8'h99, 32'h22222222, 9'b000001110, 8'h12, 0, 8'h34, 32'h11111111));
    vq.push_back(mk("rx_w1_drop",9'b000000000, 0, 0, 0, 0, 9'b000001010, 8'h12, 0, 8'h34, 32'h11111111));
    vq.push_back(mk("pop0",     9'b000000001, 0, 0, 0, 0, 9'b000001010, 8'h12, 0, 8'h34, 32'h22222222));
    vq.push_back(mk("pop1",     9'b000000001, 0, 0, 0, 0, 9'b000001000, 8'h12, 0, 8'h34, 0));
    vq.push_back(mk("pop_idle", 9'b000000001, 0, 0, 0, 0, 9'b000001000, 8'h12, 0, 8'h34, 0));

    foreach (vq[i]) begin
      {RESET, HOST_TX_WR, HOST_TX_START, TX_ACK, TX_SUCC, TX_FAIL,
       RX_REQ, RX_PEND, HOST_RX_RD} = vq[i].ctl;
      HOST_TX_WDATA = vq[i].wdata; HOST_TX_DEST = vq[i].dest;
      RX_ADDR = vq[i].raddr; RX_DATA = vq[i].rdata;
      tick();
      check({vq[i].name, "_flags"}, 64'(flags()), 64'(vq[i].e_flag));
      check({vq[i].name, "_tx"}, 64'({TX_ADDR, TX_DATA}), 64'({vq[i].e_txaddr, vq[i].e_txdata}));
      check({vq[i].name, "_rx"}, 64'({HOST_RX_ADDR, HOST_RX_RDATA}), 64'({vq[i].e_rxaddr, vq[i].e_rxdata}));
    end
    {RESET, HOST_TX_WR, HOST_TX_START, TX_ACK, TX_SUCC, TX_FAIL, RX_REQ, RX_PEND, HOST_RX_RD} = '0;

    // Three-word message: PEND 1,1,0 and no request while ACK is high.
    run_tx("a", 3, 32'h0000_0010, 8'h56, 3);
    TX_SUCC = 1'b1; tick();
    check("a_done", 64'({HOST_TX_DONE, TX_RESP_ACK, HOST_TX_OK}), 64'(3'b111));
    TX_SUCC = 1'b0; tick();
    check("a_idle", 64'({HOST_TX_DONE, TX_RESP_ACK, HOST_TX_BUSY}), 64'(3'b000));

    // Failure while waiting in the inter-word gap aborts the message.
    write_words(3, 32'h0000_0200);
    start_msg(8'h57);
    wait_req("b_req0");
    TX_ACK = 1'b1; tick();
    check("b_gap_noreq", 64'(TX_REQ), 64'(0));
    TX_FAIL = 1'b1; tick();
    check("b_abort", 64'({TX_REQ, HOST_TX_DONE, TX_RESP_ACK, HOST_TX_OK}), 64'(4'b0110));
    TX_FAIL = 1'b0; TX_ACK = 1'b0; tick();
    check("b_idle", 64'({TX_REQ, HOST_TX_DONE, HOST_TX_BUSY}), 64'(3'b000));
    tick();
    check("b_noreissue", 64'(TX_REQ), 64'(0));

    // Success sets OK; simultaneous SUCC and FAIL clears it.
    run_tx("c1", 1, 32'h0000_0300, 8'h58, 1);
    TX_SUCC = 1'b1; tick();
    check("c1_ok", 64'({HOST_TX_DONE, HOST_TX_OK}), 64'(2'b11));
    TX_SUCC = 1'b0; tick();
    run_tx("c2", 1, 32'h0000_0400, 8'h59, 1);
    TX_SUCC = 1'b1; TX_FAIL = 1'b1; tick();
    check("c2_ok", 64'({HOST_TX_DONE, HOST_TX_OK}), 64'(2'b10));
    TX_SUCC = 1'b0; TX_FAIL = 1'b0; tick();
    check("c2_pulse", 64'({HOST_TX_DONE, TX_RESP_ACK}), 64'(2'b00));

    // Five writes into a four-deep buffer: fifth is dropped.
    run_tx("f", 5, 32'h0000_1000, 8'h5A, 4);
    TX_SUCC = 1'b1; tick();
    check("f_ok", 64'({HOST_TX_DONE, HOST_TX_OK}), 64'(2'b11));
    TX_SUCC = 1'b0; tick();

    // Five-word RX message overflows; a new offer while VALID is ignored.
    rx_word("d0", 8'h77, 32'h100, 1'b1);
    for (int i = 1; i < 5; i++)
      rx_word($sformatf("d%0d", i), 8'h88, 32'h100 + 32'(i), i < 4);
    check("d_held", 64'({HOST_RX_VALID, HOST_RX_ERR, HOST_RX_ADDR}), 64'({2'b11, 8'h77}));
    RX_REQ = 1'b1; RX_PEND = 1'b0; RX_DATA = 32'hBAD; RX_ADDR = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("d_blocked%0d", k), 64'(RX_ACK), 64'(0));
    end
    RX_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d_pop%0d", i), 64'({HOST_RX_VALID, HOST_RX_RDATA}), 64'({1'b1, 32'h100 + 32'(i)}));
      HOST_RX_RD = 1'b1; tick(); HOST_RX_RD = 1'b0;
    end
    check("d_empty", 64'({HOST_RX_VALID, HOST_RX_ERR}), 64'(2'b00));

    // Reset while a TX word is requested and an RX word is being acked.
    write_words(2, 32'h0000_5000);
    RX_REQ = 1'b1; RX_PEND = 1'b1; RX_ADDR = 8'h21; RX_DATA = 32'h777;
    start_msg(8'h66);
    check("e_pre", 64'({TX_REQ, RX_ACK, HOST_TX_OK}), 64'(3'b111));
    RESET = 1'b1; tick();
    check("e_rst_flags", 64'(flags()), 64'(0));
    check("e_rst_tx", 64'({TX_ADDR, TX_DATA}), 64'(0));
    check("e_rst_rx", 64'({HOST_RX_ADDR, HOST_RX_RDATA}), 64'(0));
    RESET = 1'b0; RX_REQ = 1'b0; RX_PEND = 1'b0;
    start_msg(8'h44);
    check("e_start_empty", 64'({TX_REQ, HOST_TX_BUSY, TX_ADDR}), 64'(0));
    tick();
    check("e_still_idle", 64'({TX_REQ, HOST_TX_BUSY}), 64'(0));

    // Post-reset traffic proves counts and pointers restarted from zero.
    run_tx("g", 1, 32'hCAFE_F00D, 8'h3C, 1);
    TX_SUCC = 1'b1; tick(); TX_SUCC = 1'b0; tick();
    rx_word("g_rx", 8'h55, 32'hDEAD_BEEF, 1'b0);
    check("g_rx_held", 64'({HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_RDATA}), 64'({1'b1, 8'h55, 32'hDEAD_BEEF}));
    HOST_RX_RD = 1'b1; tick(); HOST_RX_RD = 1'b0;
    check("g_rx_popped", 64'(HOST_RX_VALID), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
